// File: rtl/counter_n.sv
// Parametrised up/down counter with enable, clear, clamped load and wrap/saturate modes.
// Defining COUNTER_PRESCALER_EN adds a prescaler so val steps once every PRESCALE enabled cycles.
module counter_n #(
    parameter int WIDTH    = 2,
    parameter int MAX      = 2**WIDTH-1,
    parameter bit SATURATE = 1'b0,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] val,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    // Elaboration-time guards against configurations the datapath cannot represent.
    if (WIDTH < 1) begin : g_bad_width
        $error("counter_n: WIDTH must be >= 1");
    end
    if (MAX < 1 || MAX > 2**WIDTH-1) begin : g_bad_max
        $error("counter_n: MAX must satisfy 0 < MAX <= 2**WIDTH-1");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("counter_n: PRESCALE must be >= 2");
    end

    logic [WIDTH-1:0] val_reg, val_next;
    logic             wrap_reg, wrap_next;
    logic             sat_reg, sat_next;
    logic [WIDTH-1:0] match_max;
    logic             at_max, at_zero, at_bound;
    logic             step;

    // Per-bit comparison against the modulus; at_max is the AND of all bit matches.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_match
        assign match_max[gi] = (val_reg[gi] == MAX_V[gi]);
    end

    assign at_max   = &match_max;
    assign at_zero  = ~|val_reg;
    assign at_bound = up ? at_max : at_zero;

`ifdef COUNTER_PRESCALER_EN
    localparam int            PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE-1);
    localparam logic [PW-1:0] PS_ONE  = PW'(1);

    logic [PW-1:0] ps_reg, ps_next;

    assign step = en & (ps_reg == PS_LAST);

    always_comb begin
        ps_next = ps_reg;
        if (clr || load) begin
            ps_next = '0;
        end else if (en) begin
            ps_next = (ps_reg == PS_LAST) ? '0 : ps_reg + PS_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= ps_next;
        end
    end
`else
    assign step = en;
`endif

    always_comb begin
        val_next  = val_reg;
        wrap_next = 1'b0;
        sat_next  = sat_reg;
        if (clr) begin
            val_next = '0;
            sat_next = 1'b0;
        end else if (load) begin
            val_next = (load_val > MAX_V) ? MAX_V : load_val;
            sat_next = 1'b0;
        end else if (step) begin
            if (at_bound) begin
                if (SATURATE) begin
                    sat_next = 1'b1;
                end else begin
                    val_next  = up ? '0 : MAX_V;
                    wrap_next = 1'b1;
                end
            end else begin
                val_next = up ? val_reg + ONE_V : val_reg - ONE_V;
                sat_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val_reg  <= '0;
            wrap_reg <= 1'b0;
            sat_reg  <= 1'b0;
        end else begin
            val_reg  <= val_next;
            wrap_reg <= wrap_next;
            sat_reg  <= sat_next;
        end
    end

    assign val  = val_reg;
    assign wrap = wrap_reg;
    assign sat  = sat_reg;
    assign tc   = step & at_bound;

endmodule

// File: tb/tb_counter_n.sv
// Scoreboard bench for counter_n: three configurations share one stimulus stream,
// each scoreboard entry names the instance it checks.
module tb_counter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;

    logic [1:0] val0;
    logic       tc0, wrap0, sat0;
    logic [3:0] val1, val2;
    logic       tc1, wrap1, sat1, tc2, wrap2, sat2;

    always #5 clk = ~clk;

    counter_n dut0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[1:0]), .val(val0), .tc(tc0), .wrap(wrap0), .sat(sat0)
    );

    counter_n #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .val(val1), .tc(tc1), .wrap(wrap1), .sat(sat1)
    );

    counter_n #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .val(val2), .tc(tc2), .wrap(wrap2), .sat(sat2)
    );

    typedef struct {
        string      name;
        int         sel;
        int         exp_tc;   // -1: tc not checked this cycle
        logic [3:0] exp_val;
        logic       exp_wrap;
        logic       exp_sat;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic get_out(input int s, output logic [3:0] v, output logic w,
                           output logic st, output logic t);
        case (s)
            0:       begin v = {2'b00, val0}; w = wrap0; st = sat0; t = tc0; end
            1:       begin v = val1; w = wrap1; st = sat1; t = tc1; end
            default: begin v = val2; w = wrap2; st = sat2; t = tc2; end
        endcase
    endtask

    task automatic chk(input string name, input string field, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, exp);
        end
    endtask

    // Drive one clock of stimulus and queue the expected response.
    task automatic cyc(input string name, input int s, input bit r, input bit c, input bit l,
                       input logic [3:0] lv, input bit e, input bit u, input int etc,
                       input logic [3:0] ev, input bit ew, input bit es);
        item_t it;
        @(negedge clk);
        rst = r; clr = c; load = l; load_val = lv; en = e; up = u;
        it.name = name; it.sel = s; it.exp_tc = etc;
        it.exp_val = ev; it.exp_wrap = ew; it.exp_sat = es;
        sb.push_back(it);
    endtask

    // Monitor: tc sampled mid-cycle with inputs applied; registers sampled after the edge.
    initial begin
        item_t      it;
        logic [3:0] v;
        logic       w, st, t, tc_pre;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) continue;
            it = sb[0];
            get_out(it.sel, v, w, st, tc_pre);
            @(posedge clk);
            #1;
            it = sb.pop_front();
            get_out(it.sel, v, w, st, t);
            if (it.exp_tc >= 0) chk(it.name, "tc", int'(tc_pre), it.exp_tc);
            chk(it.name, "val", int'(v), int'(it.exp_val));
            chk(it.name, "wrap", int'(w), int'(it.exp_wrap));
            chk(it.name, "sat", int'(st), int'(it.exp_sat));
            $display("%s: dut%0d val=%0d wrap=%0d sat=%0d tc_before=%0d", it.name, it.sel, v, w, st, tc_pre);
        end
    end

    initial begin
`ifdef COUNTER_PRESCALER_EN
        // Prescale 4 on the default 2-bit counter.
        cyc("ps_rst", 0, 1, 0, 0, 4'd0, 0, 1, -1, 4'd0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            cyc($sformatf("ps_run%0d", k), 0, 0, 0, 0, 4'd0, 1, 1,
                (k == 16) ? 1 : 0, 4'(((k) / 4) % 4), (k == 16), 0);
        end
        cyc("ps_rst2", 0, 1, 0, 0, 4'd0, 0, 1, 0, 4'd0, 0, 0);
        cyc("ps_c1", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
        cyc("ps_c2", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
        cyc("ps_c3", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
        cyc("ps_c4", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0);
        cyc("ps_c5", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0);
        cyc("ps_c6_clr", 0, 0, 1, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
        cyc("ps_c7", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
        cyc("ps_c8", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
        cyc("ps_c9", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
        cyc("ps_c10", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0);
`else
        // Default 2-bit wrap counter counting up.
        cyc("def_rst", 0, 1, 0, 0, 4'd0, 0, 1, -1, 4'd0, 0, 0);
        cyc("def_up1", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0);
        cyc("def_up2", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd2, 0, 0);
        cyc("def_up3", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd3, 0, 0);
        cyc("def_wrap", 0, 0, 0, 0, 4'd0, 1, 1, 1, 4'd0, 1, 0);
        cyc("def_up5", 0, 0, 0, 0, 4'd0, 1, 1, 0, 4'd1, 0, 0);
        // MAX=9 wrap counter counting down through zero.
        cyc("m9_load2", 1, 0, 0, 1, 4'd2, 0, 0, 0, 4'd2, 0, 0);
        cyc("m9_dn1", 1, 0, 0, 0, 4'd0, 1, 0, 0, 4'd1, 0, 0);
        cyc("m9_dn0", 1, 0, 0, 0, 4'd0, 1, 0, 0, 4'd0, 0, 0);
        cyc("m9_wrap", 1, 0, 0, 0, 4'd0, 1, 0, 1, 4'd9, 1, 0);
        cyc("m9_dn8", 1, 0, 0, 0, 4'd0, 1, 0, 0, 4'd8, 0, 0);
        // MAX=9 saturating counter: hold at 9, en=0 keeps sat, direction change releases it.
        cyc("sat_load8", 2, 0, 0, 1, 4'd8, 0, 1, 0, 4'd8, 0, 0);
        cyc("sat_up9", 2, 0, 0, 0, 4'd0, 1, 1, 0, 4'd9, 0, 0);
        cyc("sat_hold1", 2, 0, 0, 0, 4'd0, 1, 1, 1, 4'd9, 0, 1);
        cyc("sat_hold2", 2, 0, 0, 0, 4'd0, 1, 1, 1, 4'd9, 0, 1);
        cyc("sat_hold3", 2, 0, 0, 0, 4'd0, 1, 1, 1, 4'd9, 0, 1);
        cyc("sat_en0", 2, 0, 0, 0, 4'd0, 0, 1, 0, 4'd9, 0, 1);
        cyc("sat_dn8", 2, 0, 0, 0, 4'd0, 1, 0, 0, 4'd8, 0, 0);
        // Priority rst > clr > load > en, then load clamping.
        cyc("pri_load5", 1, 0, 0, 1, 4'd5, 0, 1, 0, 4'd5, 0, 0);
        cyc("pri_all", 1, 1, 1, 1, 4'd7, 1, 1, 0, 4'd0, 0, 0);
        cyc("pri_clr_load", 1, 0, 1, 1, 4'd7, 0, 1, 0, 4'd0, 0, 0);
        cyc("pri_clamp", 1, 0, 0, 1, 4'd12, 0, 1, 0, 4'd9, 0, 0);
        cyc("pri_wrap_up", 1, 0, 0, 0, 4'd0, 1, 1, 1, 4'd0, 1, 0);
        cyc("pri_en0_clrwrap", 1, 0, 0, 0, 4'd0, 0, 1, 0, 4'd0, 0, 0);
        // Idle hold, then reset in the middle of a count.
        cyc("idle_load2", 1, 0, 0, 1, 4'd2, 0, 1, 0, 4'd2, 0, 0);
        cyc("idle1", 1, 0, 0, 0, 4'd0, 0, 1, 0, 4'd2, 0, 0);
        cyc("idle2", 1, 0, 0, 0, 4'd0, 0, 1, 0, 4'd2, 0, 0);
        cyc("idle3", 1, 0, 0, 0, 4'd0, 0, 1, 0, 4'd2, 0, 0);
        cyc("mid_up3", 1, 0, 0, 0, 4'd0, 1, 1, 0, 4'd3, 0, 0);
        cyc("mid_up4", 1, 0, 0, 0, 4'd0, 1, 1, 0, 4'd4, 0, 0);
        cyc("mid_up5", 1, 0, 0, 0, 4'd0, 1, 1, 0, 4'd5, 0, 0);
        cyc("mid_up6", 1, 0, 0, 0, 4'd0, 1, 1, 0, 4'd6, 0, 0);
        cyc("mid_rst", 1, 1, 0, 0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
`endif
        @(negedge clk);
        rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("drain", "pending", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
